// File: rtl/axi_mem_pkg.sv
// Shared codes, widths and FSM state types for the AXI memory responder.
package axi_mem_pkg;

  localparam int unsigned LINE_OFF_W = 7;

  localparam logic [1:0] BURST_INCR         = 2'b01;
  localparam logic [2:0] SIZE_64B           = 3'd3;
  localparam logic [1:0] RESP_OKAY          = 2'b00;
  localparam logic [1:0] RESP_SLVERR        = 2'b10;
  localparam logic [3:0] SNOOP_MAKE_INVALID = 4'b1101;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP, W_SNOOP} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rd_state_e;

  // Only 64-bit INCR bursts touch the array; anything else is answered with SLVERR.
  function automatic logic bad_req(input logic [1:0] burst, input logic [2:0] size);
    return (burst != BURST_INCR) || (size != SIZE_64B);
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Word array with one byte-masked synchronous write port and one combinational read port.
module axi_mem_array #(
  parameter int unsigned WORDS  = 4096,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned IDX_W  = $clog2(WORDS)
) (
  input  logic                clk,
  input  logic                i_we,
  input  logic [IDX_W-1:0]    i_waddr,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W/8-1:0] i_wstrb,
  input  logic [IDX_W-1:0]    i_raddr,
  output logic [DATA_W-1:0]   o_rdata_c
);

  logic [DATA_W-1:0] r_mem [WORDS];

  // Contents intentionally survive reset.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(DATA_W / 8); b++) begin
        if (i_wstrb[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/axi_mem_responder.sv
// AXI4 slave memory: INCR read/write bursts served from an internal array, with a
// MakeInvalid snoop on the AC channel after every successful write.
module axi_mem_responder
  import axi_mem_pkg::*;
#(
  parameter int unsigned ID_WIDTH     = 13,
  parameter int unsigned ADDR_WIDTH   = 64,
  parameter int unsigned DATA_WIDTH   = 64,
  parameter int unsigned MEM_WORDS    = 4096,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [ADDR_WIDTH-1:0]   s_axi_acaddr,
  output logic [3:0]              s_axi_acsnoop,
  output logic                    s_axi_acvalid,
  input  logic                    s_axi_acready
);

  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);
  localparam int unsigned LAT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY) : 1;
  localparam int unsigned LINE_W = ADDR_WIDTH - LINE_OFF_W;

  wr_state_e                 r_wstate;
  logic                      r_awready, r_wready, r_bvalid, r_acvalid;
  logic [ID_WIDTH-1:0]       r_wid, r_bid;
  logic [1:0]                r_bresp;
  logic [LINE_W-1:0]         r_wline;
  logic [ADDR_WIDTH-1:0]     r_acaddr;
  logic [3:0]                r_acsnoop;
  logic [7:0]                r_wlen, r_wbeat;
  logic                      r_werr, r_wlast_err;
  logic [IDX_W-1:0]          r_widx;

  rd_state_e                 r_rstate;
  logic                      r_arready, r_rvalid, r_rlast, r_rerr;
  logic [ID_WIDTH-1:0]       r_rid;
  logic [DATA_WIDTH-1:0]     r_rdata;
  logic [1:0]                r_rresp;
  logic [7:0]                r_rlen, r_rbeat;
  logic [IDX_W-1:0]          r_ridx;
  logic [LAT_W-1:0]          r_lat;

  logic [IDX_W-1:0]          w_aw_idx, w_ar_idx, w_mem_raddr;
  logic [DATA_WIDTH-1:0]     w_mem_rdata;
  logic                      w_mem_we, w_ar_bad;
  logic                      w_unused;

  assign w_aw_idx    = s_axi_awaddr[3 +: IDX_W];
  assign w_ar_idx    = s_axi_araddr[3 +: IDX_W];
  assign w_ar_bad    = bad_req(s_axi_arburst, s_axi_arsize);
  assign w_mem_we    = (r_wstate == W_DATA) && s_axi_wvalid && !r_werr && !reset;
  // While idle the read port looks ahead at the incoming AR address for zero-wait latency.
  assign w_mem_raddr = (r_rstate == R_IDLE) ? w_ar_idx : r_ridx;
  assign w_unused    = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awaddr[2:0],
                         s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_araddr};

  axi_mem_array #(.WORDS(MEM_WORDS), .DATA_W(DATA_WIDTH)) u_array (
    .clk       (clk),
    .i_we      (w_mem_we),
    .i_waddr   (r_widx),
    .i_wdata   (s_axi_wdata),
    .i_wstrb   (s_axi_wstrb),
    .i_raddr   (w_mem_raddr),
    .o_rdata_c (w_mem_rdata)
  );

  // Write path: AW -> W beats -> B -> AC snoop (snoop skipped for rejected bursts).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wstate    <= W_IDLE;
      r_awready   <= 1'b1;
      r_wready    <= 1'b0;
      r_bvalid    <= 1'b0;
      r_bid       <= '0;
      r_bresp     <= '0;
      r_acvalid   <= 1'b0;
      r_acaddr    <= '0;
      r_acsnoop   <= '0;
      r_wid       <= '0;
      r_wline     <= '0;
      r_wlen      <= '0;
      r_wbeat     <= '0;
      r_werr      <= 1'b0;
      r_wlast_err <= 1'b0;
      r_widx      <= '0;
    end else begin
      case (r_wstate)
        W_IDLE: if (s_axi_awvalid) begin
          r_wstate    <= W_DATA;
          r_awready   <= 1'b0;
          r_wready    <= 1'b1;
          r_wid       <= s_axi_awid;
          r_wline     <= s_axi_awaddr[ADDR_WIDTH-1:LINE_OFF_W];
          r_wlen      <= s_axi_awlen;
          r_wbeat     <= '0;
          r_werr      <= bad_req(s_axi_awburst, s_axi_awsize);
          r_wlast_err <= 1'b0;
          r_widx      <= w_aw_idx;
        end
        W_DATA: if (s_axi_wvalid) begin
          r_widx <= r_widx + IDX_W'(1);
          if (r_wbeat == r_wlen) begin
            r_wstate <= W_RESP;
            r_wready <= 1'b0;
            r_bvalid <= 1'b1;
            r_bid    <= r_wid;
            r_bresp  <= (r_werr || r_wlast_err || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
          end else begin
            r_wbeat <= r_wbeat + 8'd1;
            if (s_axi_wlast) r_wlast_err <= 1'b1;
          end
        end
        W_RESP: if (s_axi_bready) begin
          r_bvalid <= 1'b0;
          if (r_werr) begin
            r_wstate  <= W_IDLE;
            r_awready <= 1'b1;
          end else begin
            r_wstate  <= W_SNOOP;
            r_acvalid <= 1'b1;
            r_acaddr  <= {r_wline, LINE_OFF_W'(0)};
            r_acsnoop <= SNOOP_MAKE_INVALID;
          end
        end
        W_SNOOP: if (s_axi_acready) begin
          r_wstate  <= W_IDLE;
          r_acvalid <= 1'b0;
          r_awready <= 1'b1;
        end
        default: r_wstate <= W_IDLE;
      endcase
    end
  end

  // Read path: AR -> latency wait -> R beats; each beat is captured so it stays stable under stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rid     <= '0;
      r_rdata   <= '0;
      r_rresp   <= '0;
      r_rerr    <= 1'b0;
      r_rlen    <= '0;
      r_rbeat   <= '0;
      r_ridx    <= '0;
      r_lat     <= '0;
    end else begin
      case (r_rstate)
        R_IDLE: if (s_axi_arvalid) begin
          r_arready <= 1'b0;
          r_rid     <= s_axi_arid;
          r_rlen    <= s_axi_arlen;
          r_rbeat   <= '0;
          r_lat     <= '0;
          r_rerr    <= w_ar_bad;
          r_rresp   <= w_ar_bad ? RESP_SLVERR : RESP_OKAY;
          if (READ_LATENCY == 1) begin
            r_rstate <= R_DATA;
            r_rvalid <= 1'b1;
            r_rdata  <= w_ar_bad ? '0 : w_mem_rdata;
            r_rlast  <= (s_axi_arlen == '0);
            r_ridx   <= w_ar_idx + IDX_W'(1);
          end else begin
            r_rstate <= R_WAIT;
            r_ridx   <= w_ar_idx;
          end
        end
        R_WAIT: if (r_lat == LAT_W'(READ_LATENCY - 2)) begin
          r_rstate <= R_DATA;
          r_rvalid <= 1'b1;
          r_rdata  <= r_rerr ? '0 : w_mem_rdata;
          r_rlast  <= (r_rlen == '0);
          r_ridx   <= r_ridx + IDX_W'(1);
        end else begin
          r_lat <= r_lat + LAT_W'(1);
        end
        R_DATA: if (s_axi_rready) begin
          if (r_rlast) begin
            r_rstate  <= R_IDLE;
            r_rvalid  <= 1'b0;
            r_rlast   <= 1'b0;
            r_arready <= 1'b1;
          end else begin
            r_rbeat <= r_rbeat + 8'd1;
            r_rdata <= r_rerr ? '0 : w_mem_rdata;
            r_rlast <= ((r_rbeat + 8'd1) == r_rlen);
            r_ridx  <= r_ridx + IDX_W'(1);
          end
        end
        default: r_rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi_awready = r_awready;
  assign s_axi_wready  = r_wready;
  assign s_axi_bid     = r_bid;
  assign s_axi_bresp   = r_bresp;
  assign s_axi_bvalid  = r_bvalid;
  assign s_axi_acaddr  = r_acaddr;
  assign s_axi_acsnoop = r_acsnoop;
  assign s_axi_acvalid = r_acvalid;
  assign s_axi_arready = r_arready;
  assign s_axi_rid     = r_rid;
  assign s_axi_rdata   = r_rdata;
  assign s_axi_rresp   = r_rresp;
  assign s_axi_rlast   = r_rlast;
  assign s_axi_rvalid  = r_rvalid;

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: scoreboard queues for R/B/AC checked by a negedge monitor.
module tb_axi_mem_responder;

  localparam int unsigned ID_W         = 13;
  localparam int          MEM_WORDS    = 4096;
  localparam int unsigned READ_LATENCY = 2;
  localparam int          LIM          = 200;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [63:0]     data;
    logic [1:0]      resp;
    logic            last;
  } r_exp_t;
  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } b_exp_t;
  typedef struct packed {
    logic [63:0] addr;
    logic [3:0]  snoop;
  } ac_exp_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [ID_W-1:0] s_axi_awid;
  logic [63:0]     s_axi_awaddr;
  logic [7:0]      s_axi_awlen;
  logic [2:0]      s_axi_awsize;
  logic [1:0]      s_axi_awburst;
  logic            s_axi_awlock;
  logic [3:0]      s_axi_awcache;
  logic [2:0]      s_axi_awprot;
  logic            s_axi_awvalid, s_axi_awready;
  logic [63:0]     s_axi_wdata;
  logic [7:0]      s_axi_wstrb;
  logic            s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic [ID_W-1:0] s_axi_bid;
  logic [1:0]      s_axi_bresp;
  logic            s_axi_bvalid, s_axi_bready;
  logic [ID_W-1:0] s_axi_arid;
  logic [63:0]     s_axi_araddr;
  logic [7:0]      s_axi_arlen;
  logic [2:0]      s_axi_arsize;
  logic [1:0]      s_axi_arburst;
  logic            s_axi_arlock;
  logic [3:0]      s_axi_arcache;
  logic [2:0]      s_axi_arprot;
  logic            s_axi_arvalid, s_axi_arready;
  logic [ID_W-1:0] s_axi_rid;
  logic [63:0]     s_axi_rdata;
  logic [1:0]      s_axi_rresp;
  logic            s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [63:0]     s_axi_acaddr;
  logic [3:0]      s_axi_acsnoop;
  logic            s_axi_acvalid, s_axi_acready;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  r_exp_t  exp_r[$];
  b_exp_t  exp_b[$];
  ac_exp_t exp_ac[$];
  logic [63:0] mdl [MEM_WORDS];

  axi_mem_responder #(
    .ID_WIDTH(ID_W), .ADDR_WIDTH(64), .DATA_WIDTH(64),
    .MEM_WORDS(MEM_WORDS), .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(s_axi_awlock),
    .s_axi_awcache(s_axi_awcache), .s_axi_awprot(s_axi_awprot),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(s_axi_arlock),
    .s_axi_arcache(s_axi_arcache), .s_axi_arprot(s_axi_arprot),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
    .s_axi_acaddr(s_axi_acaddr), .s_axi_acsnoop(s_axi_acsnoop),
    .s_axi_acvalid(s_axi_acvalid), .s_axi_acready(s_axi_acready)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Negedge monitor: latency, R payload stability, and scoreboard pops on handshakes.
  int      ar_cyc = 0;
  bit      lat_pend = 1'b0;
  bit      r_held = 1'b0;
  logic [95:0] held;
  r_exp_t  m_r;
  b_exp_t  m_b;
  ac_exp_t m_ac;

  always @(negedge clk) begin
    if (reset !== 1'b0) begin
      lat_pend = 1'b0;
      r_held   = 1'b0;
    end else begin
      if (s_axi_arvalid && s_axi_arready) begin
        ar_cyc   = cyc;
        lat_pend = 1'b1;
      end
      if (s_axi_rvalid) begin
        if (lat_pend) begin
          check("r_latency", 96'(cyc - ar_cyc), 96'(READ_LATENCY));
          lat_pend = 1'b0;
        end
        if (r_held) check("r_stable", 96'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast}), held);
        if (s_axi_rready) begin
          r_held = 1'b0;
          check("r_expected", 96'(exp_r.size() != 0), 96'(1));
          if (exp_r.size() != 0) begin
            m_r = exp_r.pop_front();
            check("r_id",   96'(s_axi_rid),   96'(m_r.id));
            check("r_data", 96'(s_axi_rdata), 96'(m_r.data));
            check("r_resp", 96'(s_axi_rresp), 96'(m_r.resp));
            check("r_last", 96'(s_axi_rlast), 96'(m_r.last));
          end
        end else begin
          r_held = 1'b1;
          held   = 96'({s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast});
        end
      end else begin
        r_held = 1'b0;
      end
      if (s_axi_bvalid && s_axi_bready) begin
        check("b_expected", 96'(exp_b.size() != 0), 96'(1));
        if (exp_b.size() != 0) begin
          m_b = exp_b.pop_front();
          check("b_id",   96'(s_axi_bid),   96'(m_b.id));
          check("b_resp", 96'(s_axi_bresp), 96'(m_b.resp));
        end
      end
      if (s_axi_acvalid && s_axi_acready) begin
        check("ac_expected", 96'(exp_ac.size() != 0), 96'(1));
        if (exp_ac.size() != 0) begin
          m_ac = exp_ac.pop_front();
          check("ac_addr",  96'(s_axi_acaddr),  96'(m_ac.addr));
          check("ac_snoop", 96'(s_axi_acsnoop), 96'(m_ac.snoop));
        end
      end
    end
  end

  task automatic do_write(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len,
                          input logic [1:0] burst, input logic [63:0] base, input logic [7:0] strb);
    logic        err;
    int          n;
    int          k;
    logic [63:0] d;
    err = (burst != 2'b01);
    exp_b.push_back(b_exp_t'{id, (err ? 2'b10 : 2'b00)});
    if (!err) exp_ac.push_back(ac_exp_t'{{addr[63:7], 7'b0}, 4'b1101});
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awburst = burst; s_axi_awsize = 3'd3; s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < LIM) begin tick(); n++; end
    check("aw_timeout", 96'(n < LIM), 96'(1));
    tick();
    s_axi_awvalid = 1'b0;
    check("wready_after_aw", 96'(s_axi_wready), 96'(1));
    for (int i = 0; i <= len; i++) begin
      d = base + 64'(i);
      k = (int'(addr[14:3]) + i) % MEM_WORDS;
      if (!err) begin
        for (int b = 0; b < 8; b++) if (strb[b]) mdl[k][8*b +: 8] = d[8*b +: 8];
      end
      s_axi_wdata = d; s_axi_wstrb = strb; s_axi_wlast = (i == len); s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < LIM) begin tick(); n++; end
      check("w_timeout", 96'(n < LIM), 96'(1));
      tick();
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    check("b_after_last_w", 96'(s_axi_bvalid), 96'(1));
    check("awready_low_before_ac", 96'(s_axi_awready), 96'(0));
    n = 0;
    while ((exp_b.size() != 0 || exp_ac.size() != 0) && n < LIM) begin tick(); n++; end
    check("b_ac_timeout", 96'(n < LIM), 96'(1));
  endtask

  task automatic issue_ar(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len);
    int n;
    for (int i = 0; i <= len; i++)
      exp_r.push_back(r_exp_t'{id, mdl[(int'(addr[14:3]) + i) % MEM_WORDS], 2'b00, (i == len)});
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arburst = 2'b01; s_axi_arsize = 3'd3; s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < LIM) begin tick(); n++; end
    check("ar_timeout", 96'(n < LIM), 96'(1));
    tick();
    s_axi_arvalid = 1'b0;
  endtask

  task automatic do_read(input logic [ID_W-1:0] id, input logic [63:0] addr, input int len,
                         input bit toggle);
    int n;
    issue_ar(id, addr, len);
    n = 0;
    while (exp_r.size() != 0 && n < LIM) begin
      if (toggle) s_axi_rready = ~s_axi_rready;
      tick();
      n++;
    end
    check("r_timeout", 96'(n < LIM), 96'(1));
    s_axi_rready = 1'b1;
  endtask

  initial begin
    int n;
    reset = 1'b1;
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd3;
    s_axi_awburst = 2'b01; s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd3;
    s_axi_arburst = 2'b01; s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1; s_axi_acready = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_awready", 96'(s_axi_awready), 96'(1));
    check("rst_arready", 96'(s_axi_arready), 96'(1));
    check("rst_wready",  96'(s_axi_wready),  96'(0));
    check("rst_bvalid",  96'(s_axi_bvalid),  96'(0));
    check("rst_rvalid",  96'(s_axi_rvalid),  96'(0));
    check("rst_acvalid", 96'(s_axi_acvalid), 96'(0));
    check("rst_rdata",   96'(s_axi_rdata),   96'(0));
    check("rst_acaddr",  96'(s_axi_acaddr),  96'(0));

    // Single beat write then readback
    do_write(13'h005, 64'h100, 0, 2'b01, 64'hDEADBEEF_CAFEF00D, 8'hFF);
    do_read(13'h007, 64'h100, 0, 1'b0);

    // 16-beat burst, read back with rready toggling
    do_write(13'h011, 64'h1000, 15, 2'b01, 64'h0, 8'hFF);
    do_read(13'h012, 64'h1000, 15, 1'b1);

    // Partial strobe over a known word
    do_write(13'h020, 64'h208, 0, 2'b01, 64'hAAAAAAAA_AAAAAAAA, 8'hFF);
    do_write(13'h021, 64'h208, 0, 2'b01, 64'h11223344_556677FF, 8'h0F);
    do_read(13'h022, 64'h208, 0, 1'b0);
    check("strobe_model", 96'(mdl[65]), 96'(64'hAAAAAAAA_556677FF));

    // WRAP burst rejected: SLVERR, no snoop, array untouched
    do_write(13'h030, 64'h100, 3, 2'b10, 64'h55555555_55555555, 8'hFF);
    repeat (4) tick();
    do_read(13'h031, 64'h100, 0, 1'b0);

    // Burst crossing the array end
    do_write(13'h040, 64'((MEM_WORDS - 2) * 8), 3, 2'b01, 64'h0000_0100, 8'hFF);
    do_read(13'h041, 64'((MEM_WORDS - 2) * 8), 3, 1'b0);
    do_read(13'h042, 64'h0, 1, 1'b0);

    // Reset in the middle of a 16-beat read
    issue_ar(13'h050, 64'h1000, 15);
    n = 0;
    while (exp_r.size() > 11 && n < LIM) begin tick(); n++; end
    check("mid_reset_timeout", 96'(n < LIM), 96'(1));
    reset = 1'b1;
    exp_r.delete();
    tick();
    check("mid_reset_rvalid",  96'(s_axi_rvalid),  96'(0));
    check("mid_reset_arready", 96'(s_axi_arready), 96'(1));
    check("mid_reset_rlast",   96'(s_axi_rlast),   96'(0));
    reset = 1'b0;
    tick();
    do_read(13'h051, 64'h100, 0, 1'b0);

    repeat (5) tick();
    check("r_queue_empty",  96'(exp_r.size()),  96'(0));
    check("b_queue_empty",  96'(exp_b.size()),  96'(0));
    check("ac_queue_empty", 96'(exp_ac.size()), 96'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
